// File: rtl/demux_pkg.sv
// Purpose: shared types and helpers for the handshaked word demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

  localparam int HACK_WORD_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // True when a select value addresses a channel that actually exists.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_ch);
    return sel < num_ch;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// Purpose: one-entry output register for a single demux channel, data zeroed while empty.
// Latency: 1 cycle from wr_en_i to valid_o.
// Backpressure: holds data until ready_i; a write in the same cycle as ready_i refills it.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  slot_state_e      r_state;
  slot_state_e      w_state_nxt;
  logic             w_load;
  logic [WIDTH-1:0] r_data;

  // Slot occupancy register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data register; only loaded on an accepted write so a full slot stays stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= data_i;
    end
  end

  // Next occupancy; flush dominates (the top also blocks writes while flushing).
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (flush_i) begin
      w_state_nxt = SLOT_EMPTY;
    end else begin
      case (r_state)
        SLOT_EMPTY: begin
          if (wr_en_i) begin
            w_state_nxt = SLOT_FULL;
            w_load      = 1'b1;
          end
        end
        SLOT_FULL: begin
          if (wr_en_i) begin
            w_load = 1'b1;
          end else if (ready_i) begin
            w_state_nxt = SLOT_EMPTY;
          end
        end
        default: w_state_nxt = SLOT_EMPTY;
      endcase
    end
  end

  assign valid_o = (r_state == SLOT_FULL);
  assign data_o  = valid_o ? r_data : '0;

endmodule

// File: rtl/demux_stream.sv
// Purpose: route one input word per cycle to one of NUM_CH registered valid/ready channels.
// Latency: 1 cycle from input accept to out_valid_o; bad_sel_o also 1 cycle after accept.
// Backpressure: in_ready_o drops only when the addressed slot is full and not draining, or on flush.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int WIDTH  = HACK_WORD_W,
  parameter  int NUM_CH = 8,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [WIDTH-1:0]        value_i,
  output logic [NUM_CH-1:0]       out_valid_o,
  input  logic [NUM_CH-1:0]       out_ready_i,
  output logic [NUM_CH*WIDTH-1:0] out_data_o,
  output logic                    bad_sel_o,
  output logic [CNT_W-1:0]        drop_cnt_o
);

  logic              w_in_range;
  logic              w_blocked;
  logic              w_accept;
  logic [NUM_CH-1:0] w_wr_en;
  logic              r_bad_sel;
  logic [CNT_W-1:0]  r_drop_cnt;

  assign w_in_range = sel_in_range(32'(sel_i), NUM_CH);

  // Addressed slot is blocked when full and its consumer is not taking it this cycle.
  // An out-of-range select matches no channel and so is never blocked.
  always_comb begin
    w_blocked = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel_i == SEL_W'(k)) begin
        w_blocked = out_valid_o[k] && !out_ready_i[k];
      end
    end
  end

  assign in_ready_o = !flush_i && !w_blocked;
  assign w_accept   = in_valid_i && in_ready_o;

  // One-hot write enable towards the addressed slot.
  always_comb begin
    w_wr_en = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_wr_en[k] = w_accept && w_in_range && (sel_i == SEL_W'(k));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .wr_en_i (w_wr_en[g]),
        .ready_i (out_ready_i[g]),
        .data_i  (value_i),
        .valid_o (out_valid_o[g]),
        .data_o  (out_data_o[g*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Registered one-cycle pulse for an accepted word with a nonexistent destination.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bad_sel <= 1'b0;
    end else begin
      r_bad_sel <= w_accept && !w_in_range;
    end
  end

  // Saturating dropped-word counter; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_drop_cnt <= '0;
    end else if (w_accept && !w_in_range && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign bad_sel_o  = r_bad_sel;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_demux_stream.sv
// Purpose: scoreboard bench for demux_stream, 8-channel and 5-channel instances.
// Latency: expects output one cycle after accept.
// Backpressure: consumer ready driven directly per test.
module tb_demux_stream;

  logic clk;
  logic rst;

  // 8-channel instance
  logic         flush8, vld8, rdy8;
  logic [2:0]   sel8;
  logic [15:0]  val8;
  logic [7:0]   ovld8, ordy8;
  logic [127:0] odat8;
  logic         bad8;
  logic [7:0]   drop8;

  // 5-channel instance
  logic         flush5, vld5, rdy5;
  logic [2:0]   sel5;
  logic [15:0]  val5;
  logic [4:0]   ovld5, ordy5;
  logic [79:0]  odat5;
  logic         bad5;
  logic [7:0]   drop5;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  typedef struct {
    int          ch;
    logic [15:0] dat;
  } exp_t;
  exp_t sb[$];

  demux_stream #(.WIDTH(16), .NUM_CH(8), .CNT_W(8)) u_dut8 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush8),
    .in_valid_i  (vld8),
    .in_ready_o  (rdy8),
    .sel_i       (sel8),
    .value_i     (val8),
    .out_valid_o (ovld8),
    .out_ready_i (ordy8),
    .out_data_o  (odat8),
    .bad_sel_o   (bad8),
    .drop_cnt_o  (drop8)
  );

  demux_stream #(.WIDTH(16), .NUM_CH(5), .CNT_W(8)) u_dut5 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush5),
    .in_valid_i  (vld5),
    .in_ready_o  (rdy5),
    .sel_i       (sel5),
    .value_i     (val5),
    .out_valid_o (ovld5),
    .out_ready_i (ordy5),
    .out_data_o  (odat5),
    .bad_sel_o   (bad5),
    .drop_cnt_o  (drop5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] d);
    exp_t e;
    e.ch  = ch;
    e.dat = d;
    sb.push_back(e);
  endtask

  task automatic drop_ch(input int ch);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].ch == ch) sb.delete(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake on the 8-channel instance pops the oldest expected word of that channel.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 8; k++) begin
        if (ovld8[k] && ordy8[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].ch == k) idx = i;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected ch%0d: got %h expected no word", k, odat8[k*16 +: 16]);
          end else begin
            chk($sformatf("sb_data ch%0d", k), 64'(odat8[k*16 +: 16]), 64'(sb[idx].dat));
            sb.delete(idx);
          end
        end
        if (!ovld8[k]) chk($sformatf("zero_gate ch%0d", k), 64'(odat8[k*16 +: 16]), 64'h0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush8 = 1'b0; vld8 = 1'b0; sel8 = '0; val8 = '0; ordy8 = '0;
    flush5 = 1'b0; vld5 = 1'b0; sel5 = '0; val5 = '0; ordy5 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 64'(ovld8), 64'h00);
    chk("rst_data", 64'(odat8 != '0), 64'h0);
    chk("rst_drop", 64'(drop8), 64'h0);
    chk("rst_bad", 64'(bad8), 64'h0);
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      #0.1;
      chk($sformatf("rst_ready sel%0d", s), 64'(rdy8), 64'h1);
    end
    mon_en = 1'b1;
    tick();

    // Single write, backpressure on the same channel, other channel still open
    ordy8 = 8'h00;
    vld8 = 1'b1; sel8 = 3'd3; val8 = 16'h1234;
    #1 chk("wr3_ready", 64'(rdy8), 64'h1);
    push(3, 16'h1234);
    tick();
    vld8 = 1'b0;
    chk("wr3_valid", 64'(ovld8), 64'h08);
    chk("wr3_data", 64'(odat8[3*16 +: 16]), 64'h1234);
    vld8 = 1'b1; sel8 = 3'd3; val8 = 16'h5555;
    #1 chk("wr3_blocked", 64'(rdy8), 64'h0);
    tick();
    sel8 = 3'd5; val8 = 16'hABCD;
    #1 chk("wr5_ready", 64'(rdy8), 64'h1);
    push(5, 16'hABCD);
    tick();
    vld8 = 1'b0;
    chk("wr35_valid", 64'(ovld8), 64'h28);
    chk("wr3_held", 64'(odat8[3*16 +: 16]), 64'h1234);
    ordy8 = 8'hFF;
    tick();
    ordy8 = 8'h00;
    chk("drain_valid", 64'(ovld8), 64'h00);

    // Streaming one word per cycle through channel 0
    ordy8 = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      vld8 = 1'b1; sel8 = 3'd0; val8 = 16'(i);
      #1 chk($sformatf("stream_ready %0d", i), 64'(rdy8), 64'h1);
      push(0, 16'(i));
      if (i > 1) begin
        chk($sformatf("stream_valid %0d", i), 64'(ovld8[0]), 64'h1);
        chk($sformatf("stream_data %0d", i), 64'(odat8[15:0]), 64'(i - 1));
      end
      tick();
    end
    vld8 = 1'b0;
    chk("stream_last", 64'(odat8[15:0]), 64'h4);
    tick();
    chk("stream_empty", 64'(ovld8[0]), 64'h0);
    ordy8 = 8'h00;

    // Flush with channels 1,2 full; channel 1 drains during the flush cycle
    vld8 = 1'b1; sel8 = 3'd1; val8 = 16'h0011;
    push(1, 16'h0011);
    tick();
    sel8 = 3'd2; val8 = 16'h0022;
    push(2, 16'h0022);
    tick();
    chk("pre_flush_valid", 64'(ovld8), 64'h06);
    sel8 = 3'd4; val8 = 16'h0044; flush8 = 1'b1; ordy8 = 8'h02;
    #1 chk("flush_ready", 64'(rdy8), 64'h0);
    tick();
    flush8 = 1'b0; vld8 = 1'b0; ordy8 = 8'h00;
    drop_ch(2);
    chk("flush_valid", 64'(ovld8), 64'h00);
    tick();
    chk("flush_ch4_empty", 64'(ovld8), 64'h00);

    // Reset while all channels are full and a write is pending
    for (int k = 0; k < 8; k++) begin
      vld8 = 1'b1; sel8 = 3'(k); val8 = 16'h0100 + 16'(k);
      push(k, 16'h0100 + 16'(k));
      tick();
    end
    chk("all_full", 64'(ovld8), 64'hFF);
    sel8 = 3'd3; val8 = 16'hDEAD; rst = 1'b1;
    tick();
    rst = 1'b0; vld8 = 1'b0;
    for (int k = 0; k < 8; k++) drop_ch(k);
    chk("rst2_valid", 64'(ovld8), 64'h00);
    chk("rst2_data", 64'(odat8 != '0), 64'h0);
    chk("rst2_drop", 64'(drop8), 64'h0);
    chk("rst2_bad", 64'(bad8), 64'h0);
    tick();
    chk("rst2_stays_empty", 64'(ovld8), 64'h00);

    // Out-of-range select on the 5-channel instance
    vld5 = 1'b1; sel5 = 3'd6; val5 = 16'h7777;
    #1 chk("bad_ready", 64'(rdy5), 64'h1);
    tick();
    vld5 = 1'b0;
    chk("bad_valid", 64'(ovld5), 64'h00);
    chk("bad_pulse", 64'(bad5), 64'h1);
    chk("bad_drop1", 64'(drop5), 64'h1);
    tick();
    chk("bad_pulse_end", 64'(bad5), 64'h0);
    chk("bad_drop_hold", 64'(drop5), 64'h1);
    flush5 = 1'b1;
    #1 chk("bad_flush_ready", 64'(rdy5), 64'h0);
    tick();
    flush5 = 1'b0;
    chk("bad_flush_nodrop", 64'(drop5), 64'h1);
    vld5 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 253) chk("drop_254", 64'(drop5), 64'd254);
      tick();
    end
    vld5 = 1'b0;
    chk("drop_sat", 64'(drop5), 64'hFF);
    chk("drop_sat_valid", 64'(ovld5), 64'h00);
    tick();
    chk("drop_sat_hold", 64'(drop5), 64'hFF);
    chk("drop_sat_bad_end", 64'(bad5), 64'h0);

    tick();
    mon_en = 1'b0;
    chk("sb_leftover", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised, handshaked successor to the fixed 8-way combinational word demultiplexer in the Memory hierarchy.
- Routes one input word per cycle to one of NUM_CH output channels, selected by sel_i.
- Each channel has a one-entry output register with valid/ready, so a stalled consumer blocks only writes aimed at it.
- Sits between the CPU write path and the RAM/peripheral banks. Supports an out-of-range select check, a flush, and a saturating count of dropped words.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- NUM_CH, 8, number of output channels; 2..64, power of two not required.
- SEL_W, $clog2(NUM_CH), select width; derived, not overridden.
- CNT_W, 8, width of the dropped-word counter.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of all channel slots.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  input word accepted this cycle when in_valid_i is also high.
- sel_i  in  SEL_W  destination channel index; qualified by in_valid_i.
- value_i  in  WIDTH  input word.
- out_valid_o  out  NUM_CH  per-channel slot full.
- out_ready_i  in  NUM_CH  per-channel consumer ready.
- out_data_o  out  NUM_CH*WIDTH  channel k data on bits [k*WIDTH +: WIDTH].
- bad_sel_o  out  1  one-cycle pulse: a word with sel_i >= NUM_CH was accepted and dropped.
- drop_cnt_o  out  CNT_W  saturating count of dropped words.

Behaviour:
- Reset (rst_i=1 at clock edge): out_valid_o all 0, all slot data 0, bad_sel_o=0, drop_cnt_o=0. Reset mid-transfer discards slot contents, no output pulse.
- Channel slot states: EMPTY (valid 0) and FULL (valid 1). Each channel is independent.
- Transitions for channel k:
  - EMPTY -> FULL on an input accept with sel_i==k.
  - FULL -> EMPTY on out_ready_i[k] with no write to k.
  - FULL -> FULL with new data on out_ready_i[k] and a write to k in the same cycle. This gives full throughput of one word per cycle per channel.
  - FULL holds when out_ready_i[k]=0.
- out_data_o slice k is '0 while out_valid_o[k]=0. Unselected and empty channels read zero.
- Output data is registered; latency from input accept to out_valid_o is 1 cycle.
- Input ready rules:
  - sel_i < NUM_CH: in_ready_o = !flush_i && (!out_valid_o[sel_i] || out_ready_i[sel_i]).
  - in_ready_o is combinational from sel_i, flush_i and out_ready_i. It must not depend on in_valid_i.
  - Accept = in_valid_i && in_ready_o.
- Out-of-range select (sel_i >= NUM_CH, only possible when NUM_CH is not a power of two):
  - in_ready_o = !flush_i. The word is accepted and discarded.
  - bad_sel_o pulses high the next cycle (registered).
  - drop_cnt_o increments and saturates at all-ones; no wrap.
- Flush: flush_i=1 clears all out_valid_o next cycle. in_ready_o=0 that cycle, so no accept occurs. Consumer handshakes in the flush cycle still complete on the current data. Flush wins over any simultaneous write.
- Valid/ready protocol:
  - Once out_valid_o[k]=1, the slot and its data stay stable until out_ready_i[k] or flush/reset.
  - Upstream holds value_i and sel_i stable while in_valid_i=1 and in_ready_o=0.
- No combinational path from in_valid_i to any output.

Decomposition:
- demux_pkg:
  - slot_state_e {SLOT_EMPTY, SLOT_FULL}.
  - function sel_in_range(sel, num_ch).
  - localparam HACK_WORD_W=16.
- Sub-module demux_slot, instantiated NUM_CH times by generate:
  - One-entry register with wr_en, data_i, ready_i, flush_i, rst_i, valid_o, data_o (zero-gated).
- The top holds sel decode, in_ready_o mux, bad-select pulse and the drop counter.

Test Plan:
- Reset then idle, WIDTH=16, NUM_CH=8 -> out_valid_o=8'h00, all out_data_o=0, drop_cnt_o=0, in_ready_o=1 for every sel.
- Write 16'h1234 to sel=3, out_ready_i=0 -> next cycle out_valid_o=8'h08, slice 3=16'h1234. Second write to sel=3 gives in_ready_o=0. A write to sel=5 is accepted.
- Streaming to sel=0 with out_ready_i[0]=1 every cycle, words 1,2,3,4 -> one word per cycle, out_data slice 0 = 1,2,3,4 on consecutive cycles, in_ready_o never drops.
- NUM_CH=5, write sel=6 -> accepted, no out_valid_o change, bad_sel_o pulses one cycle, drop_cnt_o=1. Repeat 300 times with CNT_W=8 -> drop_cnt_o holds 8'hFF.
- Channels 1,2 full; assert flush_i with in_valid_i=1, sel=4 -> in_ready_o=0, next cycle out_valid_o=0, channel 4 stays empty.
- rst_i asserted while channels 0..7 full and a write is in progress -> next cycle all outputs are at their reset values and the in-flight word is lost.
